sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_sched_word.sv | 14 +
 rtl/sha256_msg_schedule.sv | 145 ++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and message-schedule sigma functions,
// used by both the message schedule and the round stage.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, STREAM} state_t;

  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_BLK_WORDS = 16;

  function automatic word_t s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational next-word generator for the SHA-256 message schedule window.
module sha256_sched_word
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w_new
);

  assign w_new = w0 + s0(w1) + w9 + s1(w14);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[0..63] from a 16-word sliding window.
// Define SHA256_SCHED_PRELOAD_EN for a one-entry pending block buffer (gapless blocks).
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block_data,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         busy
);

  localparam logic [5:0] LAST_T = 6'(SHA256_ROUNDS - 1);

  state_t     state_q, state_d;
  logic [5:0] t_q, t_d;
  word_t      win_q [SHA256_BLK_WORDS];
  word_t      w_new;
  logic       blk_hs, w_hs, last_hs;
  logic       load_blk, shift_win;
`ifdef SHA256_SCHED_PRELOAD_EN
  logic         pend_vld_q, pend_vld_d;
  logic [511:0] pend_q;
  logic         load_pend, store_pend;
`endif

  sha256_sched_word u_word (
    .w0   (win_q[0]),
    .w1   (win_q[1]),
    .w9   (win_q[9]),
    .w14  (win_q[14]),
    .w_new(w_new)
  );

  assign w_valid = (state_q == STREAM);
  assign busy    = (state_q == STREAM);
  assign w_out   = w_valid ? win_q[0] : '0;
  assign w_idx   = t_q;
  assign w_last  = w_valid && (t_q == LAST_T);

`ifdef SHA256_SCHED_PRELOAD_EN
  assign blk_ready = (state_q == IDLE) || ((state_q == STREAM) && !pend_vld_q);
`else
  assign blk_ready = (state_q == IDLE);
`endif

  // Handshakes are never honoured while reset is asserted
  assign blk_hs  = blk_valid && blk_ready && !rst;
  assign w_hs    = w_valid && w_ready && !rst;
  assign last_hs = w_hs && (t_q == LAST_T);

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    load_blk  = 1'b0;
    shift_win = 1'b0;
`ifdef SHA256_SCHED_PRELOAD_EN
    pend_vld_d = pend_vld_q;
    load_pend  = 1'b0;
    store_pend = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (blk_hs) begin
          load_blk = 1'b1;
          t_d      = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (last_hs) begin
`ifdef SHA256_SCHED_PRELOAD_EN
          // Chain straight into the next block so W[0] follows W[63] directly
          if (pend_vld_q) begin
            load_pend  = 1'b1;
            pend_vld_d = 1'b0;
          end else if (blk_hs) begin
            load_blk = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
          t_d = '0;
        end else if (w_hs) begin
          shift_win = 1'b1;
          t_d       = t_q + 6'd1;
        end
`ifdef SHA256_SCHED_PRELOAD_EN
        if (blk_hs && !last_hs) begin
          store_pend = 1'b1;
          pend_vld_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
`ifdef SHA256_SCHED_PRELOAD_EN
      pend_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
`ifdef SHA256_SCHED_PRELOAD_EN
      pend_vld_q <= pend_vld_d;
`endif
    end
  end

  // Window datapath
  always_ff @(posedge clk) begin
    if (load_blk) begin
      for (int i = 0; i < SHA256_BLK_WORDS; i++)
        win_q[i] <= block_data[511 - 32*i -: 32];
`ifdef SHA256_SCHED_PRELOAD_EN
    end else if (load_pend) begin
      for (int i = 0; i < SHA256_BLK_WORDS; i++)
        win_q[i] <= pend_q[511 - 32*i -: 32];
`endif
    end else if (shift_win) begin
      for (int i = 0; i < SHA256_BLK_WORDS - 1; i++)
        win_q[i] <= win_q[i+1];
      win_q[SHA256_BLK_WORDS-1] <= w_new;
    end
`ifdef SHA256_SCHED_PRELOAD_EN
    if (store_pend)
      pend_q <= block_data;
`endif
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a FIPS-style W[t] expansion model.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] block_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         w_valid;
  logic         w_ready;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef logic [31:0] w64_t [64];

  logic [511:0] abc_blk = {32'h61626380, 448'h0, 32'h00000018};
  w64_t         abc_cap;

  always #5 clk = ~clk;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .block_data(block_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .w_out     (w_out),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .busy      (busy)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic model_expand(input logic [511:0] blk, output w64_t w);
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_block(input logic [511:0] blk, input bit rnd, input string nm,
                           output w64_t cap);
    w64_t        ew;
    int          got, cyc;
    bit          stall;
    logic [31:0] po;
    logic [5:0]  pi;
    logic        pl;
    model_expand(blk, ew);
    @(negedge clk);
    n_cmp++;
    if (blk_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_idle_ready: got %b want 1", nm, blk_ready);
    end
    block_data = blk; blk_valid = 1'b1; w_ready = 1'b0;
    @(negedge clk);
    blk_valid = 1'b0; block_data = rand_blk();
    n_cmp++;
    if (w_valid !== 1'b1 || w_idx !== 6'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL %s_latency: got valid=%b idx=%0d busy=%b want 1/0/1",
                        nm, w_valid, w_idx, busy);
    end
    got = 0; cyc = 0; stall = 1'b0; po = '0; pi = '0; pl = 1'b0;
    while (got < 64 && cyc < 1000) begin
      if (stall) begin
        n_cmp++;
        if (w_out !== po || w_idx !== pi || w_last !== pl) begin
          n_err++; $display("FAIL %s_stall_hold: got %h/%0d/%b want %h/%0d/%b",
                            nm, w_out, w_idx, w_last, po, pi, pl);
        end
      end
      n_cmp++;
      if (w_valid !== 1'b1 || w_out !== ew[got] || w_idx !== 6'(got) ||
          w_last !== (got == 63)) begin
        n_err++; $display("FAIL %s_word%0d: got v=%b w=%h idx=%0d last=%b want 1/%h/%0d/%b",
                          nm, got, w_valid, w_out, w_idx, w_last, ew[got], got, got == 63);
      end
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_ready) begin
        cap[got] = w_out; got++; stall = 1'b0;
      end else begin
        stall = 1'b1; po = w_out; pi = w_idx; pl = w_last;
      end
      @(negedge clk);
      cyc++;
    end
    w_ready = 1'b0;
    n_cmp++;
    if (got < 64) begin
      n_err++; $display("FAIL %s_timeout: got %0d words want 64", nm, got);
    end
    n_cmp++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || w_last !== 1'b0 || blk_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_end: got v=%b busy=%b last=%b rdy=%b want 0/0/0/1",
                        nm, w_valid, busy, w_last, blk_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b1; block_data = abc_blk; w_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (w_valid !== 1'b0 || w_out !== 32'h0 || w_idx !== 6'd0 || w_last !== 1'b0 ||
        busy !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got v=%b w=%h idx=%0d last=%b busy=%b want zeros",
                        w_valid, w_out, w_idx, w_last, busy);
    end
    rst = 1'b0; blk_valid = 1'b0; w_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: got rdy=%b v=%b want 1/0", blk_ready, w_valid);
    end
  endtask

  task automatic test_abc();
    run_block(abc_blk, 1'b0, "abc", abc_cap);
    n_cmp++;
    if (abc_cap[0] !== 32'h61626380 || abc_cap[15] !== 32'h00000018 ||
        abc_cap[16] !== 32'h61626380 || abc_cap[17] !== 32'h000F0000) begin
      n_err++; $display("FAIL abc_known: got %h %h %h %h want 61626380 00000018 61626380 000f0000",
                        abc_cap[0], abc_cap[15], abc_cap[16], abc_cap[17]);
    end
  endtask

  task automatic test_stall();
    w64_t cap;
    run_block(abc_blk, 1'b1, "stall", cap);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (cap[i] !== abc_cap[i]) begin
        n_err++; $display("FAIL stall_seq%0d: got %h want %h", i, cap[i], abc_cap[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    w64_t ew;
    int   got, cyc;
    model_expand(abc_blk, ew);
    @(negedge clk);
    block_data = abc_blk; blk_valid = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    got = 0; cyc = 0;
    while (got < 20 && cyc < 200) begin
      if (w_valid) begin
        n_cmp++;
        if (w_out !== ew[got] || w_idx !== 6'(got)) begin
          n_err++; $display("FAIL rstmid_word%0d: got %h/%0d want %h/%0d",
                            got, w_out, w_idx, ew[got], got);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (w_valid !== 1'b1 || w_idx !== 6'd20) begin
      n_err++; $display("FAIL rstmid_pre: got v=%b idx=%0d want 1/20", w_valid, w_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (w_valid !== 1'b0 || w_out !== 32'h0 || w_idx !== 6'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_after: got v=%b w=%h idx=%0d busy=%b want 0/0/0/0",
                        w_valid, w_out, w_idx, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (blk_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_ready: got %b want 1", blk_ready);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (w_valid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_quiet%0d: got v=%b want 0", i, w_valid);
      end
      @(negedge clk);
    end
    w_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    w64_t         ea, eb;
    logic [511:0] a, b;
    logic [31:0]  ex;
    int           nacc, got, cyc, last_a, b0;
    a = rand_blk(); b = rand_blk();
    model_expand(a, ea); model_expand(b, eb);
    nacc = 0; got = 0; cyc = 0; last_a = -100; b0 = -100;
    w_ready = 1'b1;
    @(negedge clk);
    while (got < 128 && cyc < 600) begin
      if (w_valid) begin
        ex = (got < 64) ? ea[got] : eb[got-64];
        n_cmp++;
        if (w_out !== ex || w_idx !== 6'(got % 64)) begin
          n_err++; $display("FAIL b2b_word%0d: got %h/%0d want %h/%0d",
                            got, w_out, w_idx, ex, got % 64);
        end
        if (got == 63) last_a = cyc;
        if (got == 64) b0 = cyc;
        got++;
      end
`ifndef SHA256_SCHED_PRELOAD_EN
      if (busy) begin
        n_cmp++;
        if (blk_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b_ready_busy: got %b want 0", blk_ready);
        end
      end
`endif
      blk_valid = (nacc < 2);
`ifdef SHA256_SCHED_PRELOAD_EN
      block_data = (nacc == 0) ? a : b;
`else
      block_data = (nacc == 0) ? a : (blk_ready ? b : rand_blk());
`endif
      if (blk_valid && blk_ready) nacc++;
      @(negedge clk);
      cyc++;
    end
    blk_valid = 1'b0;
    n_cmp++;
    if (got != 128) begin
      n_err++; $display("FAIL b2b_count: got %0d words want 128", got);
    end
`ifdef SHA256_SCHED_PRELOAD_EN
    n_cmp++;
    if (b0 != last_a + 1) begin
      n_err++; $display("FAIL b2b_gapless: got B.W0 cycle %0d want %0d", b0, last_a + 1);
    end
`else
    n_cmp++;
    if (b0 - last_a < 2) begin
      n_err++; $display("FAIL b2b_gap: got distance %0d want >=2", b0 - last_a);
    end
`endif
    n_cmp++;
    if (w_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got v=%b busy=%b want 0/0", w_valid, busy);
    end
    w_ready = 1'b0;
  endtask

  task automatic test_random();
    w64_t cap;
    for (int k = 0; k < 3; k++) run_block(rand_blk(), 1'b1, "rand", cap);
  endtask

  initial begin
    rst = 1'b1; blk_valid = 1'b0; w_ready = 1'b0; block_data = '0;
    test_reset();
    test_abc();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
